// File: rtl/stream_delay_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : stream_delay_lfsr
// Purpose  : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that supplies
//            pseudo-random stall lengths to stream_delay.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - synchronous active-high reset, loads SEED
//            en_i   - advance the register by one step
//            lfsr_o - current register value
// Revision : 1.0 - initial release
// ============================================================================
module stream_delay_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Right-shifting form of the polynomial: taps 16/14/13/11 map onto
  // bit positions 0/2/3/5, and the feedback enters at bit 15.
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= SEED;
    end else if (en_i) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  assign lfsr_o = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/stream_delay.sv
`default_nettype none
// ============================================================================
// Module   : stream_delay
// Purpose  : Valid/ready stage that holds off every handshake by a fixed or
//            pseudo-random number of cycles. The payload is never stored; it
//            passes straight through while only the handshake is delayed.
// Ports    : clk_i     - clock, rising edge
//            rst_i     - synchronous active-high reset
//            clr_i     - synchronous clear of the handshake FSM
//            payload_i - upstream payload
//            ready_o   - upstream ready
//            valid_i   - upstream valid
//            payload_o - downstream payload
//            ready_i   - downstream ready
//            valid_o   - downstream valid
// Revision : 1.0 - initial release
// ============================================================================
module stream_delay #(
  parameter int unsigned StallRandom = 0,
  parameter int unsigned FixedDelay  = 1,
  parameter type         payload_t   = logic
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     clr_i,
  input  payload_t payload_i,
  output logic     ready_o,
  input  logic     valid_i,
  output payload_t payload_o,
  input  logic     ready_i,
  output logic     valid_o
);

  localparam int unsigned c_clog  = $clog2(FixedDelay + 1);
  localparam int unsigned c_cnt_w = (c_clog > 5) ? c_clog : 5;

  assign payload_o = payload_i;

  if (StallRandom == 0 && FixedDelay == 0) begin : g_passthru

    assign valid_o = valid_i;
    assign ready_o = ready_i;

    // Clock, reset and clear have no function in pass-through mode.
    logic w_unused;
    assign w_unused = clk_i ^ rst_i ^ clr_i;

  end else begin : g_delay

    typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
    } state_e;

    state_e             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_load;   // D-1 for the transfer being accepted
    logic               w_load_en;
    logic               w_open;

    // A delay is loaded only from Idle with upstream valid, and never in a
    // cycle that is being reset or cleared; the LFSR steps on exactly these.
    assign w_load_en = (r_state == ST_IDLE) && valid_i && !rst_i && !clr_i;

    if (StallRandom != 0) begin : g_rand
      logic [15:0] w_lfsr;
      logic        w_lfsr_unused;

      stream_delay_lfsr #(
        .SEED (16'hACE1)
      ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_load_en),
        .lfsr_o (w_lfsr)
      );

      // D = 1 + lfsr[3:0], so the counter starts at lfsr[3:0].
      assign w_load        = c_cnt_w'(w_lfsr[3:0]);
      assign w_lfsr_unused = ^w_lfsr[15:4];
    end else begin : g_fixed
      localparam logic [c_cnt_w-1:0] c_fixed_m1 = c_cnt_w'(FixedDelay - 1);
      assign w_load = c_fixed_m1;
    end

    // Both directions open together, so a handshake on one side can only
    // coincide with a handshake on the other.
    assign w_open  = (r_state == ST_WAIT) && (r_cnt == '0);
    assign valid_o = w_open & valid_i;
    assign ready_o = w_open & ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (valid_i) begin
              r_cnt   <= w_load;
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_cnt_w'(1);
            end else if (valid_i && ready_i) begin
              r_state <= ST_IDLE;
            end
            // Upstream dropping valid here is a protocol violation: no
            // handshake can occur, so the FSM simply keeps waiting.
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

  end

endmodule
`default_nettype wire

// File: tb/tb_stream_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_delay
// Purpose  : Directed self-checking bench for stream_delay. Five instances
//            cover pass-through, fixed delays of 2/3/4 and the LFSR mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_delay;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst, rst_rn;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    hs_up    = 0;
  int    hs_dn    = 0;

  // pass-through
  logic  v_pt, r_pt, clr_pt, vo_pt, ro_pt;
  byte_t p_pt, po_pt;
  // FixedDelay = 3
  logic  v_d3, r_d3, clr_d3, vo_d3, ro_d3;
  byte_t p_d3, po_d3;
  // FixedDelay = 2
  logic  v_d2, r_d2, clr_d2, vo_d2, ro_d2;
  byte_t p_d2, po_d2;
  // FixedDelay = 4
  logic  v_d4, r_d4, clr_d4, vo_d4, ro_d4;
  byte_t p_d4, po_d4;
  // StallRandom = 1
  logic  v_rn, r_rn, clr_rn, vo_rn, ro_rn;
  byte_t p_rn, po_rn;

  stream_delay #(.StallRandom(0), .FixedDelay(0), .payload_t(byte_t)) u_pt (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_pt), .payload_i(p_pt), .ready_o(ro_pt),
    .valid_i(v_pt), .payload_o(po_pt), .ready_i(r_pt), .valid_o(vo_pt));

  stream_delay #(.StallRandom(0), .FixedDelay(3), .payload_t(byte_t)) u_d3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_d3), .payload_i(p_d3), .ready_o(ro_d3),
    .valid_i(v_d3), .payload_o(po_d3), .ready_i(r_d3), .valid_o(vo_d3));

  stream_delay #(.StallRandom(0), .FixedDelay(2), .payload_t(byte_t)) u_d2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_d2), .payload_i(p_d2), .ready_o(ro_d2),
    .valid_i(v_d2), .payload_o(po_d2), .ready_i(r_d2), .valid_o(vo_d2));

  stream_delay #(.StallRandom(0), .FixedDelay(4), .payload_t(byte_t)) u_d4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_d4), .payload_i(p_d4), .ready_o(ro_d4),
    .valid_i(v_d4), .payload_o(po_d4), .ready_i(r_d4), .valid_o(vo_d4));

  stream_delay #(.StallRandom(1), .FixedDelay(1), .payload_t(byte_t)) u_rn (
    .clk_i(clk), .rst_i(rst_rn), .clr_i(clr_rn), .payload_i(p_rn), .ready_o(ro_rn),
    .valid_i(v_rn), .payload_o(po_rn), .ready_i(r_rn), .valid_o(vo_rn));

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tally();
    hs_up += int'(v_rn & ro_rn);
    hs_dn += int'(vo_rn & r_rn);
  endtask

  // Starting in the Idle cycle that loads a delay, count cycles until valid_o
  // (ready_i held high), then move on to the following Idle cycle.
  task automatic measure(output int d);
    int k;
    k = 0;
    tally();
    while (vo_rn !== 1'b1 && k < 20) begin
      step();
      tally();
      k++;
    end
    d = (vo_rn === 1'b1) ? k : -1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] l;
    int          d;
    int          w;

    rst = 1'b1; rst_rn = 1'b1;
    {v_pt, r_pt, clr_pt} = '0; p_pt = '0;
    {v_d3, r_d3, clr_d3} = '0; p_d3 = '0;
    {v_d2, r_d2, clr_d2} = '0; p_d2 = '0;
    {v_d4, r_d4, clr_d4} = '0; p_d4 = '0;
    {v_rn, r_rn, clr_rn} = '0; p_rn = '0;

    // ---- reset: delayed outputs low, pass-through unaffected ----
    step();
    v_pt = 1'b1; r_pt = 1'b1; p_pt = 8'h3C; clr_pt = 1'b1;
    v_d3 = 1'b1; r_d3 = 1'b1;
    #1;
    check("pt_in_reset_valid", vo_pt, 1);
    check("pt_in_reset_ready", ro_pt, 1);
    check("pt_in_reset_payload", po_pt, 8'h3C);
    check("d3_reset_valid", vo_d3, 0);
    check("d3_reset_ready", ro_d3, 0);
    step();
    rst = 1'b0; rst_rn = 1'b0; v_d3 = 1'b0; r_d3 = 1'b0; clr_pt = 1'b0;
    #1;
    check("rn_after_reset_valid", vo_rn, 0);

    // ---- pass-through ----
    step();
    v_pt = 1'b1; r_pt = 1'b1; p_pt = 8'hA5; #1;
    check("pt_valid", vo_pt, 1);
    check("pt_ready", ro_pt, 1);
    check("pt_payload", po_pt, 8'hA5);
    v_pt = 1'b0; r_pt = 1'b1; p_pt = 8'h5A; #1;
    check("pt_valid_low", vo_pt, 0);
    check("pt_ready_high", ro_pt, 1);
    check("pt_payload2", po_pt, 8'h5A);
    v_pt = 1'b1; r_pt = 1'b0; #1;
    check("pt_valid_high", vo_pt, 1);
    check("pt_ready_low", ro_pt, 0);
    v_pt = 1'b0;

    // ---- FixedDelay=3: valid at 13, handshake, Idle at 14, next valid 17 ----
    for (int c = 10; c <= 17; c++) begin
      step();
      v_d3 = 1'b1; r_d3 = 1'b1; p_d3 = byte_t'(c);
      #1;
      check($sformatf("d3_valid_c%0d", c), vo_d3, (c == 13 || c == 17));
      check($sformatf("d3_ready_c%0d", c), ro_d3, (c == 13 || c == 17));
      check($sformatf("d3_payload_c%0d", c), po_d3, c);
    end
    step();
    v_d3 = 1'b0; #1;
    check("d3_idle_after", vo_d3, 0);

    // ---- FixedDelay=2 with downstream stall during 12..15 ----
    for (int c = 10; c <= 17; c++) begin
      step();
      v_d2 = 1'b1; r_d2 = (c < 12 || c >= 16); p_d2 = byte_t'(8'h40 + c);
      #1;
      check($sformatf("d2_valid_c%0d", c), vo_d2, (c >= 12 && c <= 16));
      check($sformatf("d2_ready_c%0d", c), ro_d2, (c == 16));
      check($sformatf("d2_payload_c%0d", c), po_d2, 8'h40 + c);
    end
    step();
    v_d2 = 1'b0;

    // ---- FixedDelay=4, clear in the second wait cycle (cycle 12) ----
    for (int c = 10; c <= 17; c++) begin
      step();
      v_d4 = 1'b1; r_d4 = 1'b1; clr_d4 = (c == 12); p_d4 = byte_t'(8'h80 + c);
      #1;
      check($sformatf("d4_valid_c%0d", c), vo_d4, (c == 17));
      check($sformatf("d4_payload_c%0d", c), po_d4, 8'h80 + c);
    end
    step();
    v_d4 = 1'b0; clr_d4 = 1'b0;

    // ---- StallRandom: 100 transfers against the LFSR reference ----
    l = 16'hACE1;
    step();
    v_rn = 1'b1; r_rn = 1'b1; p_rn = 8'hC3;
    #1;
    check("rn_payload", po_rn, 8'hC3);
    for (int n = 0; n < 100; n++) begin
      measure(d);
      check("rn_delay", d, 32'(1 + l[3:0]));
      check("rn_delay_range", 32'(d >= 1 && d <= 16), 1);
      l = lfsr_next(l);
    end
    check("rn_hs_up_count", hs_up, 100);
    check("rn_hs_balance", hs_up, hs_dn);

    // ---- reset while stalled in Wait with counter at zero ----
    r_rn = 1'b0; #1;
    w = 0;
    while (vo_rn !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("rn_stall_valid", vo_rn, 1);
    check("rn_stall_ready", ro_rn, 0);
    step();
    check("rn_stall_hold_valid", vo_rn, 1);
    rst_rn = 1'b1;
    step();
    rst_rn = 1'b0; r_rn = 1'b1; #1;
    check("rn_post_reset_valid", vo_rn, 0);
    check("rn_post_reset_ready", ro_rn, 0);
    // Seed ACE1 gives D=2; its successor 5670 gives D=1.
    measure(d);
    check("rn_reseed_delay0", d, 2);
    measure(d);
    check("rn_reseed_delay1", d, 1);
    v_rn = 1'b0;
    check("rn_hs_balance_final", hs_up, hs_dn);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
